// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity modes, parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Parity modes, shared with the receiver side.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Parity bit over the low nbits of d: even = XOR, odd = inverted XOR.
  function automatic logic parity_bit(input int mode, input logic [8:0] d, input int nbits);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 9; i++)
      if (i < nbits) x = x ^ d[i];
    return (mode == PARITY_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with registered count; read data is the head entry.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;

  // Pointers wrap naturally; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffered input, start / LSB-first data / optional parity / stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0,
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [DATA_BITS-1:0]            in_data,
  output logic                            in_ready,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT+1);
  localparam int BW = $clog2(DATA_BITS+1);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT-1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS-1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS-1);

  tx_state_e            state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_r;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 tx_r;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop, bit_end, stop_done;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign bit_end   = (clk_cnt == CLK_LAST);
  assign stop_done = (state == ST_STOP) && bit_end && (bit_cnt == STOP_LAST);
  // Pop when idle, or at the end of the last stop bit for a gapless next frame.
  assign pop       = ((state == ST_IDLE) || stop_done) && !fifo_empty;
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);
  assign tx        = tx_r;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame sequencer: every bit is held CLKS_PER_BIT cycles; tx is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      tx_r    <= 1'b1;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_r    <= 1'b1;
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (pop) begin
            shreg <= fifo_rdata;
            par_r <= parity_bit(PARITY, 9'(fifo_rdata), DATA_BITS);
            state <= ST_START;
            tx_r  <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= ST_DATA;
            tx_r    <= shreg[0];
          end else clk_cnt <= clk_cnt + CW'(1);
        end
        ST_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                state <= ST_PARITY;
                tx_r  <= par_r;
              end else begin
                state <= ST_STOP;
                tx_r  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shreg   <= shreg >> 1;
              tx_r    <= shreg[1];
            end
          end else clk_cnt <= clk_cnt + CW'(1);
        end
        ST_PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= ST_STOP;
            tx_r    <= 1'b1;
          end else clk_cnt <= clk_cnt + CW'(1);
        end
        ST_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (pop) begin
                shreg <= fifo_rdata;
                par_r <= parity_bit(PARITY, 9'(fifo_rdata), DATA_BITS);
                state <= ST_START;
                tx_r  <= 1'b0;
              end else begin
                state <= ST_IDLE;
                tx_r  <= 1'b1;
              end
            end else bit_cnt <= bit_cnt + BW'(1);
          end else clk_cnt <= clk_cnt + CW'(1);
        end
        default: begin
          state <= ST_IDLE;
          tx_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations against a per-cycle timeline model.
module tb_uart_tx;

  localparam int NC   = 4;
  localparam int MAXT = 8192;
  localparam int C_STOP [NC] = '{1, 1, 1, 2};
  localparam int C_PAR  [NC] = '{0, 2, 1, 0};
  localparam int C_CPB  [NC] = '{1, 4, 4, 1};

  logic          clk, reset;
  logic [NC-1:0] in_valid_v, in_ready, tx, busy;
  logic [7:0]    in_data;
  logic [2:0]    fifo_count [NC];

  for (genvar g = 0; g < NC; g++) begin : g_dut
    uart_tx #(
      .DATA_BITS    (8),
      .STOP_BITS    (C_STOP[g]),
      .PARITY       (C_PAR[g]),
      .CLKS_PER_BIT (C_CPB[g]),
      .FIFO_DEPTH   (4)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid_v[g]),
      .in_data    (in_data),
      .in_ready   (in_ready[g]),
      .tx         (tx[g]),
      .busy       (busy[g]),
      .fifo_count (fifo_count[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected line state after each clock edge, per configuration.
  logic exp_tx   [NC][MAXT];
  logic exp_busy [NC][MAXT];
  int   exp_cnt  [NC][MAXT];
  int   free_at  [NC];
  int   acc_cnt  [NC];
  int   cyc, total, bad;
  bit   chk_en;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cfg%0d cyc%0d: observed %0h expected %0h", tag, c, cyc, obs, exp);
    end
  endtask

  // Bit b of the serial frame carrying word w in configuration c.
  function automatic logic fbit(input int c, input logic [7:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (C_PAR[c] != 0 && b == 9) return (C_PAR[c] == 2) ? (^w) : ~(^w);
    return 1'b1;
  endfunction

  task automatic model_reset(input int r);
    for (int c = 0; c < NC; c++) begin
      for (int t = r; t < MAXT; t++) begin
        exp_tx[c][t]   = 1'b1;
        exp_busy[c][t] = 1'b0;
        exp_cnt[c][t]  = 0;
      end
      free_at[c] = 0;
    end
  endtask

  // A word accepted at edge n starts one edge later, or right after the line frees up.
  task automatic model_accept(input int c, input logic [7:0] w, input int n);
    int cpb, len, s;
    cpb = C_CPB[c];
    len = 1 + 8 + ((C_PAR[c] != 0) ? 1 : 0) + C_STOP[c];
    s   = (n + 1 > free_at[c]) ? n + 1 : free_at[c];
    for (int t = n; t < s && t < MAXT; t++) exp_cnt[c][t]++;
    for (int t = n; t < s + len * cpb && t < MAXT; t++) exp_busy[c][t] = 1'b1;
    for (int b = 0; b < len; b++)
      for (int k = 0; k < cpb; k++)
        if (s + b * cpb + k < MAXT) exp_tx[c][s + b * cpb + k] = fbit(c, w, b);
    free_at[c] = s + len * cpb;
  endtask

  // Edge monitor: counts cycles and feeds handshakes/resets into the model.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) model_reset(cyc);
      else
        for (int c = 0; c < NC; c++)
          if (in_valid_v[c] && in_ready[c]) begin
            model_accept(c, in_data, cyc);
            acc_cnt[c]++;
          end
    end
  end

  // Per-cycle comparison against the timeline, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && cyc < MAXT)
        for (int c = 0; c < NC; c++) begin
          chk("tx", c, 32'(tx[c]), 32'(exp_tx[c][cyc]));
          chk("busy", c, 32'(busy[c]), 32'(exp_busy[c][cyc]));
          chk("fifo_count", c, 32'(fifo_count[c]), exp_cnt[c][cyc]);
          chk("in_ready", c, 32'(in_ready[c]), 32'(exp_cnt[c][cyc] < 4));
        end
    end
  end

  // Offer word w to configuration c until it is taken; in_valid stays high on return.
  task automatic push(input int c, input logic [7:0] w);
    int a0;
    a0 = acc_cnt[c];
    in_data = w;
    in_valid_v[c] = 1'b1;
    for (int i = 0; i < 500 && acc_cnt[c] == a0; i++) begin
      @(posedge clk);
      #1;
    end
    if (acc_cnt[c] == a0) chk("push_timeout", c, acc_cnt[c], a0 + 1);
  endtask

  task automatic idle(input int n);
    in_valid_v = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain();
    int i;
    i = 0;
    in_valid_v = '0;
    while (busy != '0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    chk("drain", 0, 32'(busy), 32'(0));
  endtask

  initial begin
    logic [11:0] a5_seq;
    int n0;
    cyc = 0; total = 0; bad = 0; chk_en = 0;
    for (int c = 0; c < NC; c++) acc_cnt[c] = 0;
    model_reset(0);
    reset = 1'b1;
    in_valid_v = '0;
    in_data = '0;

    // Reset held three cycles, then released.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1;
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      chk("rst_tx", c, 32'(tx[c]), 32'(1));
      chk("rst_busy", c, 32'(busy[c]), 32'(0));
      chk("rst_ready", c, 32'(in_ready[c]), 32'(1));
      chk("rst_count", c, 32'(fifo_count[c]), 32'(0));
    end

    // Single word 0xA5: line sequence from the edge after acceptance.
    a5_seq = 12'b1111_0100_1010;
    push(0, 8'hA5);
    in_valid_v = '0;
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("a5_seq", 0, 32'(tx[0]), 32'(a5_seq[i]));
      if (i == 9)  chk("a5_busy_stop", 0, 32'(busy[0]), 32'(1));
      if (i == 10) chk("a5_busy_done", 0, 32'(busy[0]), 32'(0));
    end
    idle(3);

    // Burst of six with in_valid held high; the sixth lands in a full-again FIFO.
    push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55);
    push(0, 8'hAA); push(0, 8'h01); push(0, 8'h80);
    in_valid_v = '0;
    chk("burst_full_cnt", 0, 32'(fifo_count[0]), 32'(4));
    chk("burst_full_rdy", 0, 32'(in_ready[0]), 32'(0));
    drain();

    // Two stop bits between back-to-back frames.
    push(3, 8'h3C); push(3, 8'hC3);
    drain();

    // Word 0x07 with even and odd parity at four clocks per bit.
    in_data = 8'h07;
    in_valid_v = 4'b0110;
    @(posedge clk);
    #1 in_valid_v = '0;
    n0 = cyc;
    chk("par_acc", 1, acc_cnt[1], acc_cnt[2]);
    wait_cyc(n0 + 37);
    chk("par_even", 1, 32'(tx[1]), 32'(1));
    chk("par_odd", 2, 32'(tx[2]), 32'(0));
    wait_cyc(n0 + 44);
    chk("par_last", 1, 32'(busy[1]), 32'(1));
    wait_cyc(n0 + 45);
    chk("par_len", 1, 32'(busy[1]), 32'(0));
    drain();

    // Reset mid-DATA with two words queued behind 0x5A.
    push(0, 8'h5A);
    n0 = cyc;
    push(0, 8'h11); push(0, 8'h22);
    in_valid_v = '0;
    wait_cyc(n0 + 5);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", 0, 32'(tx[0]), 32'(1));
    chk("mid_rst_cnt", 0, 32'(fifo_count[0]), 32'(0));
    chk("mid_rst_busy", 0, 32'(busy[0]), 32'(0));
    idle(30);

    // Random words with random gaps on every configuration.
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < 20; k++) begin
        push(c, 8'($urandom));
        idle($urandom_range(0, 3));
      end
      drain();
    end

    chk("cyc_bound", 0, 32'(cyc < MAXT), 32'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter that sits directly upstream of the UART receiver and drives its serial input line.
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each word as: start bit, data LSB-first, optional parity, stop bit(s).
- With CLKS_PER_BIT=1 each bit lasts exactly one clk, matching the receiver's one-sample-per-clock timing so the two can be looped back directly.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- CLKS_PER_BIT, 1, clk cycles each serial bit is held (>=1).
- FIFO_DEPTH, 4, input buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  upstream word valid
- in_data  in  DATA_BITS  word to send
- in_ready  out  1  buffer can accept a word
- tx  out  1  serial line (idle high)
- busy  out  1  frame in flight or buffer non-empty
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words buffered (excludes the word in the shifter)

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values (next edge with reset=1): tx=1, busy=0, fifo_count=0, in_ready=1, FSM=IDLE, bit and clock counters=0. FIFO contents discarded.
- Reset mid-frame: tx returns to 1 on that edge; the partial frame is abandoned, not resumed.
- Handshake: transfer occurs on any edge with in_valid && in_ready.
- in_ready = (fifo_count < FIFO_DEPTH), combinational from registered count.
- When full, in_ready=0 even if a pop happens the same cycle; no push-when-full.
- in_data must be stable only in the transfer cycle.
- Pop: occurs when the FSM is in IDLE, or on the final cycle of the last stop bit, and fifo_count != 0.
- Push and pop on the same edge leave fifo_count unchanged.
- tx is a register; no combinational path from any input to tx.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1; if FIFO non-empty, pop into shift register, compute parity, go to START, tx<=0.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then DATA, tx<=shift[0].
  - DATA: each bit held CLKS_PER_BIT cycles, shift right, LSB first. After DATA_BITS bits, go to PARITY if PARITY!=0, else STOP.
  - PARITY: tx = odd/even parity bit for the word, held CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end, go to START if the FIFO is non-empty (back-to-back, no idle gap), else IDLE.
- Parity bit values:
  - even: bit = XOR of data bits.
  - odd: bit = inverted XOR of data bits.
- Latency: word accepted at edge N into an empty FIFO with FSM in IDLE → written at N, popped at N+1, tx=0 from edge N+1. The frame occupies (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
- Counters:
  - clock-divider counter: $clog2(CLKS_PER_BIT+1) bits, wraps to 0 at CLKS_PER_BIT-1.
  - bit counter: $clog2(DATA_BITS+1) bits.
  - FIFO pointers: $clog2(FIFO_DEPTH) bits, natural wrap.
- busy = (FSM != IDLE) || (fifo_count != 0).

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding localparams (IDLE, START, DATA, PARITY, STOP).
  - Parity mode constants PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2, reused later by uart_rx parity support.
- Sub-module uart_tx_fifo: synchronous FIFO, registered count, ports push/pop/wdata/rdata/count/full/empty. Parameterized by width and depth.
- Top uart_tx holds the FSM, shifter and divider.

Test Plan:
- Defaults; reset held 3 cycles, then released → tx=1, busy=0, in_ready=1, fifo_count=0.
- Single word 0xA5, CLKS_PER_BIT=1 → from one cycle after acceptance, tx = 0,1,0,1,0,0,1,0,1,1, then idle high; busy drops after the stop bit.
- Burst of 6 words 0x00,0xFF,0x55,0xAA,0x01,0x80 with in_valid held high → in_ready low while fifo_count=4. Frames are back-to-back with no gap between stop and next start. Loopback through uart_rx shows each word on its data output in the DONE cycle, in order.
- PARITY=2, CLKS_PER_BIT=4, word 0x07 → each bit lasts 4 cycles, parity bit=1, 11-bit frame = 44 cycles. With PARITY=1, parity bit=0.
- STOP_BITS=2, two words 0x3C,0xC3 → tx high exactly 2 bit-times between frames.
- Reset asserted mid-DATA of 0x5A with 2 words queued → tx=1 next edge, fifo_count=0, busy=0. No further frame starts until a new word is pushed.
